instr_fetch: RTL and testbench

- Fetch stage between the 15-bit program counter and the decode/execute logic of the Hack CPU.
- Takes the current PC value, issues a read to the synchronous instruction ROM, and buffers the returned 16-bit instruction with its address in a 2-entry queue.
- Delivers instructions to decode over a valid/ready handshake.
- Gates PC increment through `pc_advance` and discards stale fetches on a jump flush.

---
 rtl/hack_pkg.sv | 29 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU fetch path.
package hack_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned STAT_W = 16;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] addr;
  } fetch_entry_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // Saturating add for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    logic [STAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions; head register holds its value when empty.
module fetch_queue
  import hack_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               clear,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count,
  output logic               valid
);

  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  fetch_entry_t     r_mem0;
  fetch_entry_t     r_mem1;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;
  logic             w_full;

  assign w_full = (r_count == C_FULL);
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && (!w_full || w_pop);

  // Storage and occupancy; clear drops all entries but leaves the head word visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_mem0  <= '0;
      r_mem1  <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == '0) r_mem0 <= push_entry;
          else               r_mem1 <= push_entry;
          r_count <= r_count + C_ONE;
        end
        2'b01: begin
          if (w_full) r_mem0 <= r_mem1;
          r_count <= r_count - C_ONE;
        end
        2'b11: begin
          if (w_full) begin
            r_mem0 <= r_mem1;
            r_mem1 <= push_entry;
          end else begin
            r_mem0 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = r_mem0;
  assign count = r_count;
  assign valid = (r_count != '0);

endmodule

// File: rtl/instr_fetch.sv
// Hack CPU fetch stage: issues ROM reads from the PC, buffers returns, hands them to decode.
// Optional INSTR_FETCH_STATS_EN adds saturating fetched/killed counters.
module instr_fetch
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              flush,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [WORD_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef INSTR_FETCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_fetched,
  output logic [STAT_W-1:0] stat_killed
`endif
);

  localparam int unsigned LOAD_W = CNT_W + 1;

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_addr;
  logic              w_issue;
  logic              w_flush;
  logic              w_pop;
  logic              w_push;
  logic              w_valid;
  logic [CNT_W-1:0]  w_count;
  logic [LOAD_W-1:0] w_load;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_entry;

  // A head popped this cycle frees its slot, which keeps a full-rate stream gap-free.
  assign w_pop  = w_valid && instr_ready;
  assign w_load = LOAD_W'(w_count) - LOAD_W'(w_pop) + LOAD_W'(r_inflight);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= INIT;
    else        r_state <= w_state_next;
  end

  // Next state and issue decision; INIT idles one cycle and ignores flush.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      INIT: w_state_next = RUN;
      RUN: begin
        w_flush = flush;
        w_issue = !flush && (w_load < LOAD_W'(DEPTH));
      end
      default: w_state_next = INIT;
    endcase
  end

  // In-flight read tracking; a flush or reset discards the pending return.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_addr <= pc_in;
    end
  end

  assign w_push       = r_inflight && !w_flush;
  assign w_push_entry = '{word: rom_data, addr: r_inflight_addr};

  fetch_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .clear      (w_flush),
    .head       (w_head),
    .count      (w_count),
    .valid      (w_valid)
  );

  assign rom_rd      = w_issue;
  assign pc_advance  = w_issue;
  assign rom_addr    = pc_in;
  assign instr       = w_head.word;
  assign instr_pc    = w_head.addr;
  assign instr_valid = w_valid;

`ifdef INSTR_FETCH_STATS_EN
  logic [STAT_W-1:0] r_fetched;
  logic [STAT_W-1:0] r_killed;
  logic [STAT_W-1:0] w_kill_n;

  // Entries lost to a flush: queued ones not popped this cycle plus the pending return.
  assign w_kill_n = STAT_W'(w_count) - STAT_W'(w_pop) + STAT_W'(r_inflight);

  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetched <= '0;
      r_killed  <= '0;
    end else begin
      if (w_push)  r_fetched <= sat_add(r_fetched, STAT_W'(1));
      if (w_flush) r_killed  <= sat_add(r_killed, w_kill_n);
    end
  end

  assign stat_fetched = r_fetched;
  assign stat_killed  = r_killed;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle ROM model and a loadable PC model.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [14:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        rom_rd;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [14:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_load;
  logic [14:0] pc_load_val;
`ifdef INSTR_FETCH_STATS_EN
  logic [15:0] stat_fetched;
  logic [15:0] stat_killed;
  logic [15:0] k0;
`endif

  int total;
  int bad;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          chk;
    bit          rd;
    logic [14:0] addr;
    bit          vld;
    logic [15:0] ins;
    logic [14:0] ipc;
  } vec_t;

  vec_t vecs[$];

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .rom_rd      (rom_rd),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef INSTR_FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_killed (stat_killed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [14:0] a);
    return 16'hA000 + 16'(a);
  endfunction

  always @(posedge clk) if (rom_rd) rom_data <= rom_word(rom_addr);

  always @(posedge clk) begin
    if (pc_load)         pc_in <= pc_load_val;
    else if (!reset)     pc_in <= 15'd0;
    else if (pc_advance) pc_in <= pc_in + 15'd1;
  end

  function automatic vec_t mk(bit rst, bit rdy, bit chk, bit rd, logic [14:0] addr,
                              bit vld, logic [15:0] ins, logic [14:0] ipc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.chk = chk; v.rd = rd;
    v.addr = addr; v.vld = vld; v.ins = ins; v.ipc = ipc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit rst_v, input bit rdy, input bit fl, input bit ld,
                       input logic [14:0] ldv);
    @(negedge clk);
    reset       = rst_v;
    instr_ready = rdy;
    flush       = fl;
    pc_load     = ld;
    pc_load_val = ldv;
    #1;
  endtask

  task automatic expect_out(input string tag, input bit rd, input logic [14:0] addr,
                            input bit vld, input logic [15:0] ins, input logic [14:0] ipc);
    chk({tag, ".rom_rd"}, 32'(rom_rd), 32'(rd));
    chk({tag, ".pc_advance"}, 32'(pc_advance), 32'(rd));
    if (rd) chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(addr));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(vld));
    chk({tag, ".instr"}, 32'(instr), 32'(ins));
    chk({tag, ".instr_pc"}, 32'(instr_pc), 32'(ipc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; flush = 1'b0; instr_ready = 1'b1;
    pc_load = 1'b0; pc_load_val = '0; rom_data = '0;

    // Streaming with ready always high.
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 2, 1, 16'hA000, 0));
    vecs.push_back(mk(1, 1, 1, 1, 3, 1, 16'hA001, 1));
    vecs.push_back(mk(1, 1, 1, 1, 4, 1, 16'hA002, 2));
    // Back-pressure fills the queue, PC holds, then drains without gaps.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 16'hA000, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 16'hA000, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 16'hA000, 0));
    vecs.push_back(mk(1, 1, 1, 1, 2, 1, 16'hA000, 0));
    vecs.push_back(mk(1, 1, 1, 1, 3, 1, 16'hA001, 1));
    vecs.push_back(mk(1, 1, 1, 1, 4, 1, 16'hA002, 2));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rdy, 1'b0, 1'b0, '0);
      if (vecs[i].chk)
        expect_out($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].vld,
                   vecs[i].ins, vecs[i].ipc);
    end

    // Jump flush mid-stream to 0BCD: one queued entry popped, one return dropped.
`ifdef INSTR_FETCH_STATS_EN
    k0 = stat_killed;
`endif
    drive(1, 1, 1, 1, 15'h0BCD); expect_out("flush0", 0, 0, 1, 16'hA003, 15'd3);
    drive(1, 1, 0, 0, 0);        expect_out("flush1", 1, 15'h0BCD, 0, 16'hA003, 15'd3);
`ifdef INSTR_FETCH_STATS_EN
    chk("flush.stat_killed", 32'(stat_killed), 32'(k0 + 16'd1));
`endif
    drive(1, 1, 0, 0, 0);        expect_out("flush2", 1, 15'h0BCE, 0, 16'hA003, 15'd3);
    drive(1, 0, 0, 0, 0);        expect_out("flush3", 0, 0, 1, 16'hABCD, 15'h0BCD);
    drive(1, 0, 0, 0, 0);        expect_out("flush4", 0, 0, 1, 16'hABCD, 15'h0BCD);

    // Flush together with a handshake while the queue is full.
`ifdef INSTR_FETCH_STATS_EN
    k0 = stat_killed;
`endif
    drive(1, 1, 1, 1, 15'h0100); expect_out("flhs0", 0, 0, 1, 16'hABCD, 15'h0BCD);
    drive(1, 1, 0, 0, 0);        expect_out("flhs1", 1, 15'h0100, 0, 16'hABCD, 15'h0BCD);
`ifdef INSTR_FETCH_STATS_EN
    chk("flhs.stat_killed", 32'(stat_killed), 32'(k0 + 16'd1));
`endif
    drive(1, 1, 0, 0, 0);        expect_out("flhs2", 1, 15'h0101, 0, 16'hABCD, 15'h0BCD);
    drive(1, 1, 0, 0, 0);        expect_out("flhs3", 1, 15'h0102, 1, 16'hA100, 15'h0100);
    drive(1, 1, 0, 0, 0);        expect_out("flhs4", 1, 15'h0103, 1, 16'hA101, 15'h0101);

    // Reset with a full queue and a read issuing.
    drive(1, 0, 0, 0, 0);        expect_out("rstm0", 0, 0, 1, 16'hA102, 15'h0102);
    drive(0, 1, 0, 0, 0);        expect_out("rstm1", 1, 15'h0104, 1, 16'hA102, 15'h0102);
    drive(1, 1, 0, 0, 0);        expect_out("rstm2", 0, 0, 0, 16'h0000, 15'h0000);
`ifdef INSTR_FETCH_STATS_EN
    chk("rstm.stat_fetched", 32'(stat_fetched), 32'd0);
    chk("rstm.stat_killed", 32'(stat_killed), 32'd0);
`endif
    drive(1, 1, 0, 0, 0);        expect_out("rstm3", 1, 15'h0000, 0, 16'h0000, 15'h0000);
    drive(1, 1, 0, 0, 0);        expect_out("rstm4", 1, 15'h0001, 0, 16'h0000, 15'h0000);
    drive(1, 1, 0, 0, 0);        expect_out("rstm5", 1, 15'h0002, 1, 16'hA000, 15'h0000);

    // PC wrap from 7FFF to 0000.
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 15'h7FFF); expect_out("wrap0", 0, 0, 0, 16'h0000, 15'h0000);
    drive(1, 1, 0, 0, 0);        expect_out("wrap1", 1, 15'h7FFF, 0, 16'h0000, 15'h0000);
    drive(1, 1, 0, 0, 0);        expect_out("wrap2", 1, 15'h0000, 0, 16'h0000, 15'h0000);
    drive(1, 1, 0, 0, 0);        expect_out("wrap3", 1, 15'h0001, 1, 16'h1FFF, 15'h7FFF);
    drive(1, 1, 0, 0, 0);        expect_out("wrap4", 1, 15'h0002, 1, 16'hA000, 15'h0000);
`ifdef INSTR_FETCH_STATS_EN
    chk("wrap.stat_fetched", 32'(stat_fetched), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
